redirect_remap_table: RTL and testbench
=======================================

# redirect_remap_table

Per-initiator redirect remap table sitting directly downstream of the per-target-port redirect monitor. Consumes its `redirect_valid`/`source`/`target` vectors and turns their edges into install/remove events, serialised through a round-robin arbiter. Holds one remap entry per initiator with optional expiry. Answers registered lookups from the crossbar's initiator-ID path so a redirected initiator's traffic is steered to its target.

## Interface
- `N_TARG_PORT`, default 7: number of monitored target ports.
- `LOG_N_INIT`, default 2: initiator ID width. The table has N_INIT = 2**LOG_N_INIT entries.
- `TIMEOUT_W`, default 16: entry lifetime counter width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `redirect_valid_i`  in  N_TARG_PORT  per-port redirect active level from the monitor.
- `source_i`  in  N_TARG_PORT×LOG_N_INIT  per-port redirected initiator.
- `target_i`  in  N_TARG_PORT×LOG_N_INIT  per-port destination initiator.
- `timeout_i`  in  TIMEOUT_W  entry lifetime in cycles; 0 means never expire.
- `lookup_valid_i`  in  1  lookup request.
- `lookup_id_i`  in  LOG_N_INIT  initiator ID to translate.
- `lookup_valid_o`  out  1  lookup response valid.
- `lookup_hit_o`  out  1  a valid entry existed for the ID.
- `lookup_id_o`  out  LOG_N_INIT  translated ID; equals the request ID on a miss.
- `table_valid_o`  out  N_INIT  per-entry valid bits.
- `busy_o`  out  1  any event pending or in APPLY.
- `overflow_o`  out  1  sticky: a pending event was overwritten.

## Operation
- **Edge detect.** `prev` register per port, reset 0.
  - Rising edge on port p: set `pend_ins[p]`, clear `pend_rem[p]`, capture `source_i[p]`/`target_i[p]` into `psrc[p]`/`ptgt[p]`.
  - Falling edge on port p: set `pend_rem[p]`, clear `pend_ins[p]`.
  - Either edge while `pend_ins[p]|pend_rem[p]` is already set: set `overflow_o`. The newest event wins.
- **FSM, IDLE/APPLY.**
  - IDLE: if any pending bit is set, grant the lowest port index at or after `rr_ptr` (wrapping). Latch port, type, src and tgt; clear that port's pending bits; set `rr_ptr` = grant+1 mod N_TARG_PORT; go to APPLY. Otherwise stay in IDLE.
  - APPLY: perform the table write, then go to IDLE.
  - An edge on the granted port in the same IDLE cycle re-sets its pending bits. The new event is kept, with no overflow.
- **Install.**
  - If src == tgt, drop the event; no table change.
  - Otherwise `entry[src]` = {valid=1, tgt, owner=port, timer=`timeout_i` sampled in APPLY}. An existing entry is overwritten.
- **Remove.** Clear `valid` of every entry whose owner == port. If no entry matches, nothing changes.
- **Expiry.**
  - Each valid entry with nonzero timer decrements by 1 per cycle.
  - The entry is cleared in the cycle its timer would reach 0, so it stays valid for exactly `timeout_i` cycles after the APPLY cycle.
  - An APPLY write to the same entry in that cycle takes priority over decrement and expiry.
- **Lookup.** Registered, one cycle.
  - `lookup_valid_o` = `lookup_valid_i` delayed by one cycle.
  - `hit` = `entry[lookup_id_i].valid` as stored at the request cycle (before that cycle's writes).
  - `lookup_id_o` = hit ? `entry.tgt` : `lookup_id_i`.
  - Outputs hold their values when `lookup_valid_o` = 0.
- `busy_o` = (state == APPLY) | OR of all pending bits.

## Timing
- **Reset values.** Every output is 0. All entries, pending bits, `prev`, `rr_ptr`, FSM (IDLE) and `overflow_o` are cleared.
- **Reset mid-operation.** Pending and in-flight events are discarded. A `redirect_valid_i` still high after reset deasserts is treated as a fresh rising edge.
- **Edge-to-table latency, uncontended.**
  - Edge at cycle T: pending set at T+1, grant in IDLE at T+1, APPLY at T+2.
  - `table_valid_o` updates at T+3.
- **Throughput.** One event per 2 cycles. K simultaneous events complete within 2K cycles.
- **Lookup latency.** Exactly 1 cycle; a new lookup can be issued every cycle.

## Test plan
- **Basic install and lookup.** Port 0 rises with src=1, tgt=3, timeout=0 → `table_valid_o` = 0010 three cycles later. Lookup ID 1 → hit=1, id_o=3. Lookup ID 2 → hit=0, id_o=2.
- **Remove by owner.** Port 0 falls after the install above → entry 1 cleared 3 cycles later; lookup ID 1 misses.
- **Simultaneous installs with round-robin.** Ports 2, 5 and 6 rise in the same cycle, each with a distinct src, and `rr_ptr` = 4. → APPLY order is 5, 6, 2. `busy_o` drops after 6 cycles.
- **Expiry.** Install with timeout=5 → entry valid for exactly 5 cycles after APPLY, then cleared. A re-install on the expiring cycle wins and reloads the timer.
- **Overflow.** Port 3 rises, then falls while its event is still pending behind 4 other events → `overflow_o` = 1 sticky; only the remove is applied.
- **Reset mid-stream.** Assert `rst` with 3 events pending while `redirect_valid_i[1]` is held high. → All outputs 0. After release, port 1 installs once.

Source files
------------

// File: rtl/redirect_remap_table.sv
`timescale 1ns/1ps
// redirect_remap_table
// Per-initiator remap table fed by the per-target-port redirect monitor.
// Level changes on redirect_valid_i become install (rise) / remove (fall)
// events. Each port holds at most one pending event; a newer edge replaces an
// older pending one and flags overflow. A round-robin arbiter hands one event
// at a time to a two-state IDLE/APPLY machine that writes the table.
//
// Lookup interface: lookup_valid_i is a one-cycle request with no back-pressure
// (there is no ready). Every request cycle produces exactly one response cycle
// later, flagged by lookup_valid_o. Response fields hold their last value while
// lookup_valid_o is low.
module redirect_remap_table #(
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_INIT  = 2,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_TARG_PORT-1:0]            redirect_valid_i,
  input  logic [N_TARG_PORT*LOG_N_INIT-1:0] source_i,
  input  logic [N_TARG_PORT*LOG_N_INIT-1:0] target_i,
  input  logic [TIMEOUT_W-1:0]              timeout_i,
  input  logic                              lookup_valid_i,
  input  logic [LOG_N_INIT-1:0]             lookup_id_i,
  output logic                              lookup_valid_o,
  output logic                              lookup_hit_o,
  output logic [LOG_N_INIT-1:0]             lookup_id_o,
  output logic [(1<<LOG_N_INIT)-1:0]        table_valid_o,
  output logic                              busy_o,
  output logic                              overflow_o
);

  localparam int N_INIT = 1 << LOG_N_INIT;
  localparam int PW     = (N_TARG_PORT > 1) ? $clog2(N_TARG_PORT) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Edge detection and per-port pending events
  // ---------------------------------------------------------------------------
  logic [N_TARG_PORT-1:0] prev;
  logic [N_TARG_PORT-1:0] rise;
  logic [N_TARG_PORT-1:0] fall;
  logic [N_TARG_PORT-1:0] pend_ins;
  logic [N_TARG_PORT-1:0] pend_rem;
  logic [N_TARG_PORT-1:0] pend_ins_n;
  logic [N_TARG_PORT-1:0] pend_rem_n;
  logic [N_TARG_PORT-1:0] pend_any;
  logic                   ovf_evt;
  logic                   overflow_q;

  logic [LOG_N_INIT-1:0]  psrc [N_TARG_PORT];
  logic [LOG_N_INIT-1:0]  ptgt [N_TARG_PORT];

  // ---------------------------------------------------------------------------
  // Arbiter / FSM
  // ---------------------------------------------------------------------------
  state_t                 state;
  state_t                 state_n;
  logic [PW-1:0]          rr_ptr;
  logic                   arb_found;
  logic [PW-1:0]          arb_idx;
  logic                   grant_fire;

  logic [PW-1:0]          gnt_port;
  logic                   gnt_ins;
  logic [LOG_N_INIT-1:0]  gnt_src;
  logic [LOG_N_INIT-1:0]  gnt_tgt;

  // ---------------------------------------------------------------------------
  // Remap table
  // ---------------------------------------------------------------------------
  logic [N_INIT-1:0]      ent_valid;
  logic [LOG_N_INIT-1:0]  ent_tgt   [N_INIT];
  logic [PW-1:0]          ent_owner [N_INIT];
  logic [TIMEOUT_W-1:0]   ent_timer [N_INIT];
  logic [N_INIT-1:0]      apply_ins_hit;
  logic [N_INIT-1:0]      apply_rem_hit;

  assign rise     = redirect_valid_i & ~prev;
  assign fall     = ~redirect_valid_i & prev;
  assign pend_any = pend_ins | pend_rem;

  // Round-robin pick: lowest pending port at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    arb_found = 1'b0;
    arb_idx   = '0;
    j         = 0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= N_TARG_PORT) j = j - N_TARG_PORT;
      if (!arb_found && pend_any[j]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(j);
      end
    end
  end

  // Next-state logic: IDLE grants one pending event, APPLY always returns.
  always_comb begin
    state_n    = state;
    grant_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (arb_found) begin
          grant_fire = 1'b1;
          state_n    = S_APPLY;
        end
      end
      S_APPLY: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Pending update: the grant consumes first, so an edge on the granted port
  // in the same cycle lands as a fresh event rather than an overflow.
  always_comb begin
    pend_ins_n = pend_ins;
    pend_rem_n = pend_rem;
    ovf_evt    = 1'b0;
    if (grant_fire) begin
      pend_ins_n[arb_idx] = 1'b0;
      pend_rem_n[arb_idx] = 1'b0;
    end
    for (int p = 0; p < N_TARG_PORT; p++) begin
      if (rise[p] || fall[p]) begin
        if (pend_ins_n[p] || pend_rem_n[p]) ovf_evt = 1'b1;
        pend_ins_n[p] = rise[p];
        pend_rem_n[p] = fall[p];
      end
    end
  end

  // Edge history, pending bits and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      pend_ins   <= '0;
      pend_rem   <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev     <= redirect_valid_i;
      pend_ins <= pend_ins_n;
      pend_rem <= pend_rem_n;
      if (ovf_evt) overflow_q <= 1'b1;
    end
  end

  // Capture the src/tgt pair presented with each rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < N_TARG_PORT; p++) begin
        psrc[p] <= '0;
        ptgt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < N_TARG_PORT; p++) begin
        if (rise[p]) begin
          psrc[p] <= source_i[p*LOG_N_INIT +: LOG_N_INIT];
          ptgt[p] <= target_i[p*LOG_N_INIT +: LOG_N_INIT];
        end
      end
    end
  end

  // FSM state, round-robin pointer and the latched granted event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      gnt_port <= '0;
      gnt_ins  <= 1'b0;
      gnt_src  <= '0;
      gnt_tgt  <= '0;
    end else begin
      state <= state_n;
      if (grant_fire) begin
        gnt_port <= arb_idx;
        gnt_ins  <= pend_ins[arb_idx];
        gnt_src  <= psrc[arb_idx];
        gnt_tgt  <= ptgt[arb_idx];
        rr_ptr   <= (arb_idx == PW'(N_TARG_PORT - 1)) ? '0 : arb_idx + PW'(1);
      end
    end
  end

  // Which entries the APPLY cycle touches; self-remaps are dropped.
  always_comb begin
    apply_ins_hit = '0;
    apply_rem_hit = '0;
    for (int e = 0; e < N_INIT; e++) begin
      if (state == S_APPLY) begin
        if (gnt_ins) begin
          apply_ins_hit[e] = (gnt_src != gnt_tgt) && (gnt_src == LOG_N_INIT'(e));
        end else begin
          apply_rem_hit[e] = (ent_owner[e] == gnt_port);
        end
      end
    end
  end

  // Table entries: countdown/expiry first, APPLY writes override it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_valid <= '0;
      for (int e = 0; e < N_INIT; e++) begin
        ent_tgt[e]   <= '0;
        ent_owner[e] <= '0;
        ent_timer[e] <= '0;
      end
    end else begin
      for (int e = 0; e < N_INIT; e++) begin
        if (ent_valid[e] && (ent_timer[e] != '0)) begin
          if (ent_timer[e] == TIMEOUT_W'(1)) begin
            ent_valid[e] <= 1'b0;
            ent_timer[e] <= '0;
          end else begin
            ent_timer[e] <= ent_timer[e] - TIMEOUT_W'(1);
          end
        end
        if (apply_ins_hit[e]) begin
          ent_valid[e] <= 1'b1;
          ent_tgt[e]   <= gnt_tgt;
          ent_owner[e] <= gnt_port;
          ent_timer[e] <= timeout_i;
        end else if (apply_rem_hit[e]) begin
          ent_valid[e] <= 1'b0;
        end
      end
    end
  end

  // Registered lookup against the table contents before this cycle's writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_valid_o <= 1'b0;
      lookup_hit_o   <= 1'b0;
      lookup_id_o    <= '0;
    end else begin
      lookup_valid_o <= lookup_valid_i;
      if (lookup_valid_i) begin
        lookup_hit_o <= ent_valid[lookup_id_i];
        lookup_id_o  <= ent_valid[lookup_id_i] ? ent_tgt[lookup_id_i] : lookup_id_i;
      end
    end
  end

  assign table_valid_o = ent_valid;
  assign busy_o        = (state == S_APPLY) | (|pend_any);
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_redirect_remap_table.sv
`timescale 1ns/1ps
// Directed bench for redirect_remap_table: install/lookup, remove by owner,
// round-robin ordering, expiry with re-install priority, overflow and reset.
module tb_redirect_remap_table;

  localparam int NP = 7;
  localparam int LW = 2;
  localparam int TW = 16;
  localparam int NI = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     rv;
  logic [NP*LW-1:0]  src_v;
  logic [NP*LW-1:0]  tgt_v;
  logic [TW-1:0]     timeout;
  logic              lk_v;
  logic [LW-1:0]     lk_id;
  logic              lookup_valid_o;
  logic              lookup_hit_o;
  logic [LW-1:0]     lookup_id_o;
  logic [NI-1:0]     table_valid_o;
  logic              busy_o;
  logic              overflow_o;

  logic [LW:0]       exp_q[$];
  logic [LW:0]       mon_exp;
  int                checks = 0;
  int                errors = 0;

  redirect_remap_table #(
    .N_TARG_PORT(NP),
    .LOG_N_INIT (LW),
    .TIMEOUT_W  (TW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid_i(rv),
    .source_i        (src_v),
    .target_i        (tgt_v),
    .timeout_i       (timeout),
    .lookup_valid_i  (lk_v),
    .lookup_id_i     (lk_id),
    .lookup_valid_o  (lookup_valid_o),
    .lookup_hit_o    (lookup_hit_o),
    .lookup_id_o     (lookup_id_o),
    .table_valid_o   (table_valid_o),
    .busy_o          (busy_o),
    .overflow_o      (overflow_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rise_port(input int p, input int s, input int t);
    rv[p] = 1'b1;
    src_v[p*LW +: LW] = LW'(s);
    tgt_v[p*LW +: LW] = LW'(t);
  endtask

  task automatic fall_port(input int p);
    rv[p] = 1'b0;
  endtask

  task automatic lookup(input int id, input logic hit, input int tgt);
    lk_v  = 1'b1;
    lk_id = LW'(id);
    exp_q.push_back({hit, LW'(tgt)});
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every lookup response is matched against the queue head.
  always @(negedge clk) begin
    if (lookup_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL lookup_unexpected: observed hit=%0b id=%0h expected no response",
               lookup_hit_o, lookup_id_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("lookup", {29'd0, lookup_hit_o, lookup_id_o}, {29'd0, mon_exp});
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rv = '0; src_v = '0; tgt_v = '0; timeout = '0;
    lk_v = 1'b0; lk_id = '0;
    tick(); tick();
    check("rst_table",    table_valid_o,  0);
    check("rst_busy",     busy_o,         0);
    check("rst_overflow", overflow_o,     0);
    check("rst_lk_valid", lookup_valid_o, 0);
    check("rst_lk_hit",   lookup_hit_o,   0);
    check("rst_lk_id",    lookup_id_o,    0);
    rst = 1'b0;
    tick();

    // Basic install port0 src1->tgt3, then lookups
    rise_port(0, 1, 3);
    tick(); check("ins_busy_pend", busy_o, 1);
    tick(); check("ins_table_t2", table_valid_o, 4'b0000);
    tick(); check("ins_table_t3", table_valid_o, 4'b0010);
            check("ins_busy_done", busy_o, 0);
    lookup(1, 1'b1, 3); tick();
    lookup(2, 1'b0, 2); tick();
    lk_v = 1'b0; tick();
    check("lk_hold_valid", lookup_valid_o, 0);
    check("lk_hold_hit",   lookup_hit_o,   0);
    check("lk_hold_id",    lookup_id_o,    2);

    // Remove by owner
    fall_port(0);
    tick(); tick(); check("rem_table_t2", table_valid_o, 4'b0010);
    tick();         check("rem_table_t3", table_valid_o, 4'b0000);
    lookup(1, 1'b0, 1); tick();
    lk_v = 1'b0; tick();

    // Self-remap on port 3 is dropped; leaves rr_ptr at 4
    rise_port(3, 0, 0);
    tick(); tick(); tick();
    check("drop_table", table_valid_o, 4'b0000);
    check("drop_busy",  busy_o, 0);

    // Simultaneous installs on ports 2,5,6 with rr_ptr=4: order 5,6,2
    rise_port(2, 0, 1);
    rise_port(5, 2, 3);
    rise_port(6, 3, 0);
    tick(); check("rr_busy_r1", busy_o, 1);
    tick();
    tick(); check("rr_table_r3", table_valid_o, 4'b0100);
    tick();
    tick(); check("rr_table_r5", table_valid_o, 4'b1100);
    tick(); check("rr_busy_r6", busy_o, 1);
    tick(); check("rr_table_r7", table_valid_o, 4'b1101);
            check("rr_busy_r7", busy_o, 0);
    lookup(0, 1'b1, 1); tick();
    lookup(3, 1'b1, 0); tick();
    lookup(1, 1'b0, 1); tick();
    lk_v = 1'b0; tick();

    // Clear everything
    fall_port(2); fall_port(3); fall_port(5); fall_port(6);
    for (int i = 0; i < 10; i++) tick();
    check("clr1_table", table_valid_o, 4'b0000);
    check("clr1_busy",  busy_o, 0);

    // Expiry: timeout=5, valid for exactly 5 cycles after APPLY
    timeout = TW'(5);
    rise_port(4, 1, 2);
    tick(); tick();
    tick(); check("exp_first", table_valid_o, 4'b0010);
    tick(); tick(); tick();
    tick(); check("exp_last",  table_valid_o, 4'b0010);
    tick(); check("exp_clear", table_valid_o, 4'b0000);

    // Re-install on the expiring cycle reloads the timer
    timeout = TW'(4);
    rise_port(5, 2, 0);
    tick(); tick();
    tick(); check("reexp_q3", table_valid_o, 4'b0100);
    tick();
    timeout = TW'(3);
    rise_port(6, 2, 1);
    tick();
    tick(); check("reexp_q6", table_valid_o, 4'b0100);
    tick(); check("reexp_q7_wins", table_valid_o, 4'b0100);
    lookup(2, 1'b1, 1); tick();
    lk_v = 1'b0;
    tick(); check("reexp_q9", table_valid_o, 4'b0100);
    tick(); check("reexp_q10", table_valid_o, 4'b0000);

    // Clear, then set rr_ptr to 4 via a dropped port-3 event
    fall_port(4); fall_port(5); fall_port(6);
    for (int i = 0; i < 8; i++) tick();
    check("clr2_busy", busy_o, 0);
    rise_port(3, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    fall_port(3);
    for (int i = 0; i < 4; i++) tick();
    check("pre_ovf", overflow_o, 0);

    // Overflow: port 3 pending behind 4,5,6,1 then falls
    timeout = '0;
    rise_port(4, 0, 1);
    rise_port(5, 1, 2);
    rise_port(6, 2, 0);
    rise_port(1, 0, 0);
    rise_port(3, 3, 1);
    tick(); check("ovf_before", overflow_o, 0);
    fall_port(3);
    tick(); check("ovf_set", overflow_o, 1);
    for (int i = 0; i < 10; i++) tick();
    check("ovf_table",  table_valid_o, 4'b0111);
    check("ovf_busy",   busy_o, 0);
    check("ovf_sticky", overflow_o, 1);
    lookup(3, 1'b0, 3); tick();
    lk_v = 1'b0; tick();

    // Reset with 3 removes pending while port 1 stays high
    fall_port(4); fall_port(5); fall_port(6);
    tick(); check("mid_busy", busy_o, 1);
    rst = 1'b1;
    src_v[1*LW +: LW] = LW'(2);
    tgt_v[1*LW +: LW] = LW'(3);
    tick();
    check("mid_rst_table",    table_valid_o,  0);
    check("mid_rst_busy",     busy_o,         0);
    check("mid_rst_overflow", overflow_o,     0);
    check("mid_rst_lk_valid", lookup_valid_o, 0);
    check("mid_rst_lk_hit",   lookup_hit_o,   0);
    check("mid_rst_lk_id",    lookup_id_o,    0);
    tick();
    rst = 1'b0;
    tick(); check("post_rst_busy", busy_o, 1);
    tick();
    tick(); check("post_rst_table", table_valid_o, 4'b0100);
            check("post_rst_idle",  busy_o, 0);
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_once_busy", busy_o, 0);
    check("post_rst_once_ovf",  overflow_o, 0);
    lookup(2, 1'b1, 3); tick();
    lk_v = 1'b0; tick(); tick();

    check("lookup_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
